// File: rtl/sign_mag_pkg.sv
// Shared width helpers and typedefs for the sign-magnitude dot-product datapath.
package sign_mag_pkg;

   function automatic int mult_width(input int data_width);
      return 2 * data_width;
   endfunction

   function automatic int sum_width(input int data_width, input int size);
      return mult_width(data_width) + $clog2(size);
   endfunction

   localparam int DefDataWidth = 8;
   localparam int DefSize      = 4;
   localparam int DefAccWidth  = 24;

   typedef logic [DefDataWidth-1:0]                       lane_mag_t;
   typedef logic [mult_width(DefDataWidth)-1:0]           prod_mag_t;
   typedef logic [sum_width(DefDataWidth, DefSize)-1:0]   sum_t;
   typedef logic [DefAccWidth-1:0]                        result_mag_t;

   typedef struct packed {
      logic        sign;
      result_mag_t mag;
   } sm_result_t;

endpackage

// File: rtl/sign_mag_reduce.sv
// Combinational split of lane products into positive/negative sets and their unsigned sums.
module sign_mag_reduce
   import sign_mag_pkg::*;
#(
   parameter int DataWidth = 8,
   parameter int Size      = 4
) (
   input  logic [Size-1:0]                              prod_sign_i,
   input  logic [Size*mult_width(DataWidth)-1:0]        prod_mag_i,
   output logic [sum_width(DataWidth, Size)-1:0]        pos_sum_o,
   output logic [sum_width(DataWidth, Size)-1:0]        neg_sum_o
);

   localparam int MultWidth = mult_width(DataWidth);
   localparam int SumWidth  = sum_width(DataWidth, Size);

   logic [SumWidth-1:0] pos_lane [Size];
   logic [SumWidth-1:0] neg_lane [Size];

   always_comb begin
      for (int unsigned i = 0; i < Size; i++) begin
         pos_lane[i] = '0;
         neg_lane[i] = '0;
         if (prod_sign_i[i]) neg_lane[i] = SumWidth'(prod_mag_i[i*MultWidth +: MultWidth]);
         else                pos_lane[i] = SumWidth'(prod_mag_i[i*MultWidth +: MultWidth]);
      end
   end

   // Linear reduction; synthesis rebalances it into a tree.
   always_comb begin
      pos_sum_o = '0;
      neg_sum_o = '0;
      for (int unsigned i = 0; i < Size; i++) begin
         pos_sum_o = pos_sum_o + pos_lane[i];
         neg_sum_o = neg_sum_o + neg_lane[i];
      end
   end

endmodule

// File: rtl/sign_mag_dot_product.sv
// Pipelined signed dot product: S1 convert/multiply, S2 reduce, S3 accumulate, output resolve.
module sign_mag_dot_product
   import sign_mag_pkg::*;
#(
   parameter int DataWidth = 8,
   parameter int Size      = 4,
   parameter int AccWidth  = 24
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   input  logic                      in_last_i,
   input  logic [Size*DataWidth-1:0] op0_vec_i,
   input  logic [Size*DataWidth-1:0] op1_vec_i,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic                      out_sign_o,
   output logic [AccWidth-1:0]       out_mag_o,
   output logic                      out_overflow_o
);

   localparam int MultWidth = mult_width(DataWidth);
   localparam int SumWidth  = sum_width(DataWidth, Size);

   typedef logic [AccWidth:0] acc_t;
   typedef struct packed {
      logic                sign;
      logic [AccWidth-1:0] mag;
   } result_t;

   logic en;

   logic                      s1_valid_q, s1_last_q;
   logic [Size-1:0]           s1_sign_q, s1_sign_d;
   logic [Size*MultWidth-1:0] s1_mag_q, s1_mag_d;

   logic                      s2_valid_q, s2_last_q;
   logic [SumWidth-1:0]       s2_pos_q, s2_neg_q, pos_sum, neg_sum;

   acc_t                      pos_acc_q, neg_acc_q, pos_tot, neg_tot;
   logic                      ovf_q, ovf_tot;

   logic                      s3_valid_q, s3_last_q, s3_ovf_q;
   acc_t                      s3_pos_q, s3_neg_q;

   logic                      out_valid_q, out_ovf_q;
   result_t                   out_q, res_d;

   assign en         = !out_valid_q || out_ready_i;
   assign in_ready_o = en && !rst_i;

   always_comb begin
      logic [DataWidth-1:0] a, b, ma, mb;
      logic [MultWidth-1:0] p;
      s1_sign_d = '0;
      s1_mag_d  = '0;
      a = '0; b = '0; ma = '0; mb = '0; p = '0;
      for (int unsigned i = 0; i < Size; i++) begin
         a  = op0_vec_i[i*DataWidth +: DataWidth];
         b  = op1_vec_i[i*DataWidth +: DataWidth];
         ma = a[DataWidth-1] ? -a : a;
         mb = b[DataWidth-1] ? -b : b;
         p  = MultWidth'(ma) * MultWidth'(mb);
         s1_sign_d[i] = (p != '0) && (a[DataWidth-1] ^ b[DataWidth-1]);
         s1_mag_d[i*MultWidth +: MultWidth] = p;
      end
   end

   sign_mag_reduce #(
      .DataWidth (DataWidth),
      .Size      (Size)
   ) u_reduce (
      .prod_sign_i (s1_sign_q),
      .prod_mag_i  (s1_mag_q),
      .pos_sum_o   (pos_sum),
      .neg_sum_o   (neg_sum)
   );

   always_comb begin
      pos_tot = pos_acc_q + acc_t'(s2_pos_q);
      neg_tot = neg_acc_q + acc_t'(s2_neg_q);
      ovf_tot = ovf_q || pos_tot[AccWidth] || neg_tot[AccWidth];
   end

   // Totals are registered in S3 and resolved one stage later, giving the 3-edge latency.
   always_comb begin
      logic [AccWidth-1:0] p, n;
      p = s3_pos_q[AccWidth-1:0];
      n = s3_neg_q[AccWidth-1:0];
      res_d = '0;
      if (p > n) begin
         res_d.sign = 1'b0;
         res_d.mag  = p - n;
      end else if (n > p) begin
         res_d.sign = 1'b1;
         res_d.mag  = n - p;
      end
      if (s3_ovf_q) res_d.mag = '1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_valid_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         s1_sign_q   <= '0;
         s1_mag_q    <= '0;
         s2_valid_q  <= 1'b0;
         s2_last_q   <= 1'b0;
         s2_pos_q    <= '0;
         s2_neg_q    <= '0;
         pos_acc_q   <= '0;
         neg_acc_q   <= '0;
         ovf_q       <= 1'b0;
         s3_valid_q  <= 1'b0;
         s3_last_q   <= 1'b0;
         s3_ovf_q    <= 1'b0;
         s3_pos_q    <= '0;
         s3_neg_q    <= '0;
         out_valid_q <= 1'b0;
         out_ovf_q   <= 1'b0;
         out_q       <= '0;
      end else if (en) begin
         s1_valid_q <= in_valid_i;
         s1_last_q  <= in_last_i;
         s1_sign_q  <= s1_sign_d;
         s1_mag_q   <= s1_mag_d;

         s2_valid_q <= s1_valid_q;
         s2_last_q  <= s1_last_q;
         s2_pos_q   <= pos_sum;
         s2_neg_q   <= neg_sum;

         if (s2_valid_q) begin
            pos_acc_q <= s2_last_q ? '0 : pos_tot;
            neg_acc_q <= s2_last_q ? '0 : neg_tot;
            ovf_q     <= s2_last_q ? 1'b0 : ovf_tot;
         end
         s3_valid_q <= s2_valid_q;
         s3_last_q  <= s2_last_q;
         s3_pos_q   <= pos_tot;
         s3_neg_q   <= neg_tot;
         s3_ovf_q   <= ovf_tot;

         out_valid_q <= s3_valid_q && s3_last_q;
         if (s3_valid_q && s3_last_q) begin
            out_q     <= res_d;
            out_ovf_q <= s3_ovf_q;
         end
      end
   end

   assign out_valid_o    = out_valid_q;
   assign out_sign_o     = out_q.sign;
   assign out_mag_o      = out_q.mag;
   assign out_overflow_o = out_ovf_q;

endmodule

// File: doc/sign_mag_dot_product.md
# sign_mag_dot_product

Streaming, pipelined signed-integer dot-product engine built on sign-magnitude arithmetic. Each beat carries two `Size`-lane signed vectors. Per-lane products are split into positive and negative magnitude sums, accumulated over a variable number of beats, and resolved into one sign/magnitude result when the last beat arrives. It sits between the operand vector streams and the result writeback of the vector datapath, and replaces the purely combinational convert/multiply/add chain.

## Interface
Parameters:
- `DataWidth`, 8: operand width, two's complement.
- `Size`, 4: lanes per beat.
- `AccWidth`, 24: accumulator and result magnitude width. Must satisfy `AccWidth >= SumWidth`.
- Derived localparams:
  - `MultWidth = 2*DataWidth`
  - `SumWidth = MultWidth + $clog2(Size)`

Ports:
- `clk_i` in, 1: clock. One clock only.
- `rst_i` in, 1: reset, asynchronous, active-high.
- `in_valid_i` in, 1: input beat valid.
- `in_ready_o` out, 1: block accepts the beat this cycle.
- `in_last_i` in, 1: beat is the final beat of the current dot product.
- `op0_vec_i` in, `Size*DataWidth`: signed lanes, operand 0.
- `op1_vec_i` in, `Size*DataWidth`: signed lanes, operand 1.
- `out_valid_o` out, 1: result valid.
- `out_ready_i` in, 1: consumer accepts the result.
- `out_sign_o` out, 1: result sign (1 = negative).
- `out_mag_o` out, `AccWidth`: result magnitude.
- `out_overflow_o` out, 1: the result saturated.

## Operation
- Transfer rules:
  - Input transfer: `in_valid_i && in_ready_o` on a rising edge.
  - Output transfer: `out_valid_o && out_ready_i`.
- Global pipeline enable: `en = !out_valid_o || out_ready_i`.
  - `in_ready_o = en && !rst_i`.
  - When `en=0` every stage holds. Bubbles (no transfer) advance with a cleared valid bit.
- S1 (convert + multiply), registered:
  - Lane sign is the MSB. Magnitude is the two's-complement negate when negative.
  - -2^(DataWidth-1) yields magnitude 2^(DataWidth-1) in `DataWidth` unsigned bits, with no overflow.
  - Product sign = sign0 ^ sign1. Product magnitude is `MultWidth` unsigned.
  - A lane with zero magnitude has its product sign forced to 0.
  - Latched with the beat: valid and last.
- S2 (reduce), registered:
  - Lanes are routed to a pos or neg set by product sign; the other set receives 0.
  - Two unsigned adder trees produce `pos_sum` and `neg_sum`, each `SumWidth` wide.
- S3 (accumulate):
  - `pos_acc` and `neg_acc` are `AccWidth + 1`-bit unsigned registers.
  - On a valid beat each adds its sum.
  - Sticky `ovf` is set if either accumulator's bit `AccWidth` becomes 1.
- Resolve, on a valid beat with last set:
  - The output register loads the final values, compared against the summed totals including this beat:
    - If P > N: sign 0, mag = P - N.
    - If N > P: sign 1, mag = N - P.
    - If P == N: sign 0, mag 0. Negative zero is never produced.
  - If `ovf` is set (including by this beat): mag = all-ones and `out_overflow_o` = 1. Sign is still derived from the truncated compare.
  - In the same cycle, `pos_acc`, `neg_acc` and `ovf` clear.
- A single-beat dot product (last on the first beat) is legal.
- Dot-product length is unbounded except by overflow.

## Timing
- Latency: last beat accepted at edge t gives `out_valid_o` high after edge t+3, with no stalls.
- Throughput: one beat per cycle while `out_valid_o` is low or the consumer is ready.
- `out_valid_o` holding:
  - Once high, it stays high with all result fields stable until the output transfer.
  - While it is held and `out_ready_i` is low, `in_ready_o` is 0 and S1–S3 freeze.
- Output transfer with a new result arriving in the same cycle: the output register loads the new result and `out_valid_o` stays high. No cycle gap.
- Reset values (asynchronous, on `rst_i` high):
  - All stage valid bits, `pos_acc`, `neg_acc` and `ovf` are 0.
  - `out_valid_o` 0, `out_sign_o` 0, `out_mag_o` 0, `out_overflow_o` 0.
  - `in_ready_o` 0 while `rst_i` is high, and 1 from the first cycle after release.
- Reset mid-dot-product discards all in-flight beats and partial accumulation. The next accepted beat starts a fresh dot product.

## Structure
- Package `sign_mag_pkg` holds:
  - the lane-magnitude, product and result typedefs, parameterised through localparam functions for `MultWidth`/`SumWidth`;
  - the packed struct `{sign, mag}`.
- Sub-module `sign_mag_reduce`: combinational pos/neg split plus the two adder trees, instantiated once in S2.
- Conversion, multiply, accumulate and resolve stay in the top module.

## Test plan
- Single beat, `Size`=4, `DataWidth`=8: op0=[1,2,3,4], op1=[5,6,7,8], last=1 -> 3 cycles later sign 0, mag 70, overflow 0.
- Extreme operand: op0=[-128,0,0,0], op1=[-128,0,0,0] -> sign 0, mag 16384. op1=[127,0,0,0] instead -> sign 1, mag 16256.
- Two-beat cancel:
  - beat0 op0=[-1,-1,-1,-1], op1=[10,10,10,10].
  - beat1 op0=[1,0,0,0], op1=[40,0,0,0], last=1.
  - -> sign 0, mag 0, with no negative zero.
- Backpressure:
  - Stream three single-beat products back-to-back and hold `out_ready_i` low 5 cycles.
  - -> `in_ready_o` 0 and the first result stable for the whole hold.
  - After release, results arrive in order with no loss or duplication.
- Overflow, `AccWidth`=18: four beats, each op0=op1=[-128,-128,-128,-128] (65536 per beat), last on beat 4 -> `out_overflow_o` 1, mag 0x3FFFF. The following dot product reports overflow 0.
- Reset mid-operation:
  - Send two non-last beats of [1,1,1,1]·[1,1,1,1], pulse `rst_i`, then send the first test's vectors with last=1.
  - -> all outputs 0 during reset, then mag 70 with no carry-over.
